// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage instruction info and core status in,
// pipeline-register enables/flushes and performance counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_instr_i;
  logic             id_rs1_used_i;
  logic             id_rs2_used_i;
  logic             id_rd_wren_i;
  logic             id_is_load_i;
  logic             br_taken_i;
  logic             lsu_busy_i;
  logic             pc_en_o;
  logic             if_id_en_o;
  logic             if_id_flush_o;
  logic             id_ex_en_o;
  logic             id_ex_flush_o;
  logic             ex_mem_en_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // core side: supplies instruction info, consumes control
  modport master (
    output id_instr_i, id_rs1_used_i, id_rs2_used_i, id_rd_wren_i, id_is_load_i,
           br_taken_i, lsu_busy_i,
    input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
           ex_mem_en_o, stall_cnt_o, flush_cnt_o
  );

  // controller side
  modport slave (
    input  id_instr_i, id_rs1_used_i, id_rs2_used_i, id_rd_wren_i, id_is_load_i,
           br_taken_i, lsu_busy_i,
    output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
           ex_mem_en_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core. Tracks in-flight
// destination registers (EX/MEM/WB), detects RAW hazards against ID and
// resolves LSU wait > taken branch > data stall by fixed priority.
module hazard_ctrl #(
  parameter bit FORWARD   = 1'b1,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic         clk_i,
  input logic         reset_ni,
  hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic       wren;
    logic [4:0] rd;
    logic       load;
  } ent_t;

  ent_t             ex_q, mem_q, wb_q;
  logic [4:0]       rs1, rs2;
  logic             hazard, stall, flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             unused;

  // a source that is not read is folded to x0, which never matches
  assign rs1 = bus.id_rs1_used_i ? bus.id_instr_i[19:15] : 5'd0;
  assign rs2 = bus.id_rs2_used_i ? bus.id_instr_i[24:20] : 5'd0;

  assign unused = ^{bus.id_instr_i[31:25], bus.id_instr_i[14:12], bus.id_instr_i[6:0],
                    mem_q.load, wb_q.load};

  function automatic logic hit(ent_t e, logic [4:0] r);
    return e.wren && (e.rd == r) && (r != 5'd0);
  endfunction

  // RAW detection: with forwarding only load-use in EX can't be bypassed
  always_comb begin
    hazard = 1'b0;
    if (FORWARD) begin
      hazard = ex_q.load && (hit(ex_q, rs1) || hit(ex_q, rs2));
    end else begin
      hazard = hit(ex_q, rs1) || hit(ex_q, rs2) || hit(mem_q, rs1) || hit(mem_q, rs2);
      if (!WB_BYPASS) hazard = hazard || hit(wb_q, rs1) || hit(wb_q, rs2);
    end
  end

  // priority resolution of enables/flushes: reset, LSU wait, branch, stall
  always_comb begin
    bus.pc_en_o       = 1'b0;
    bus.if_id_en_o    = 1'b0;
    bus.if_id_flush_o = 1'b0;
    bus.id_ex_en_o    = 1'b0;
    bus.id_ex_flush_o = 1'b0;
    bus.ex_mem_en_o   = 1'b0;
    stall             = 1'b0;
    flush             = 1'b0;
    if (!reset_ni || bus.lsu_busy_i) begin
      // everything frozen
    end else if (bus.br_taken_i) begin
      // ID instruction is squashed, so any hazard it carries is moot
      bus.pc_en_o       = 1'b1;
      bus.if_id_en_o    = 1'b1;
      bus.if_id_flush_o = 1'b1;
      bus.id_ex_en_o    = 1'b1;
      bus.id_ex_flush_o = 1'b1;
      bus.ex_mem_en_o   = 1'b1;
      flush             = 1'b1;
    end else if (hazard) begin
      bus.id_ex_en_o    = 1'b1;
      bus.id_ex_flush_o = 1'b1;
      bus.ex_mem_en_o   = 1'b1;
      stall             = 1'b1;
    end else begin
      bus.pc_en_o       = 1'b1;
      bus.if_id_en_o    = 1'b1;
      bus.id_ex_en_o    = 1'b1;
      bus.ex_mem_en_o   = 1'b1;
    end
  end

  // shadow pipeline advances with the real one; a flushed ID/EX becomes a bubble
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.lsu_busy_i) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= bus.id_ex_flush_o ? '0 :
               ent_t'{wren: bus.id_rd_wren_i, rd: bus.id_instr_i[11:7], load: bus.id_is_load_i};
    end
  end

  // saturating performance counters
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Four configurations share one stimulus:
// a: FORWARD=1, b: FORWARD=0/WB_BYPASS=1, c: FORWARD=1/CNT_W=4,
// d: FORWARD=0/WB_BYPASS=0. Expected values are hand-derived per config.
module tb_hazard_ctrl;

  // control vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
  localparam logic [5:0] CTL_RUN   = 6'b110101;
  localparam logic [5:0] CTL_STALL = 6'b000111;
  localparam logic [5:0] CTL_FLUSH = 6'b111111;
  localparam logic [5:0] CTL_HOLD  = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h13;
  logic        r1u = 1'b0, r2u = 1'b0, wr = 1'b0, ld = 1'b0, br = 1'b0, busy = 1'b0;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) ia ();
  hazard_ctrl_if #(.CNT_W(16)) ib ();
  hazard_ctrl_if #(.CNT_W(4))  ic ();
  hazard_ctrl_if #(.CNT_W(16)) id ();

  assign ia.id_instr_i = instr; assign ia.id_rs1_used_i = r1u; assign ia.id_rs2_used_i = r2u;
  assign ia.id_rd_wren_i = wr;  assign ia.id_is_load_i = ld;   assign ia.br_taken_i = br;
  assign ia.lsu_busy_i = busy;
  assign ib.id_instr_i = instr; assign ib.id_rs1_used_i = r1u; assign ib.id_rs2_used_i = r2u;
  assign ib.id_rd_wren_i = wr;  assign ib.id_is_load_i = ld;   assign ib.br_taken_i = br;
  assign ib.lsu_busy_i = busy;
  assign ic.id_instr_i = instr; assign ic.id_rs1_used_i = r1u; assign ic.id_rs2_used_i = r2u;
  assign ic.id_rd_wren_i = wr;  assign ic.id_is_load_i = ld;   assign ic.br_taken_i = br;
  assign ic.lsu_busy_i = busy;
  assign id.id_instr_i = instr; assign id.id_rs1_used_i = r1u; assign id.id_rs2_used_i = r2u;
  assign id.id_rd_wren_i = wr;  assign id.id_is_load_i = ld;   assign id.br_taken_i = br;
  assign id.lsu_busy_i = busy;

  hazard_ctrl #(.FORWARD(1'b1), .WB_BYPASS(1'b1), .CNT_W(16)) u_a (.clk_i(clk), .reset_ni(rst_n), .bus(ia.slave));
  hazard_ctrl #(.FORWARD(1'b0), .WB_BYPASS(1'b1), .CNT_W(16)) u_b (.clk_i(clk), .reset_ni(rst_n), .bus(ib.slave));
  hazard_ctrl #(.FORWARD(1'b1), .WB_BYPASS(1'b1), .CNT_W(4))  u_c (.clk_i(clk), .reset_ni(rst_n), .bus(ic.slave));
  hazard_ctrl #(.FORWARD(1'b0), .WB_BYPASS(1'b0), .CNT_W(16)) u_d (.clk_i(clk), .reset_ni(rst_n), .bus(id.slave));

  logic [5:0] ctl_a, ctl_b, ctl_c, ctl_d;
  assign ctl_a = {ia.pc_en_o, ia.if_id_en_o, ia.if_id_flush_o, ia.id_ex_en_o, ia.id_ex_flush_o, ia.ex_mem_en_o};
  assign ctl_b = {ib.pc_en_o, ib.if_id_en_o, ib.if_id_flush_o, ib.id_ex_en_o, ib.id_ex_flush_o, ib.ex_mem_en_o};
  assign ctl_c = {ic.pc_en_o, ic.if_id_en_o, ic.if_id_flush_o, ic.id_ex_en_o, ic.id_ex_flush_o, ic.ex_mem_en_o};
  assign ctl_d = {id.pc_en_o, id.if_id_en_o, id.if_id_flush_o, id.id_ex_en_o, id.id_ex_flush_o, id.ex_mem_en_o};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // drive ID-stage fields, then let combinational outputs settle
  task automatic drv(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic w, input logic l,
                     input logic b, input logic bz);
    instr = {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
    r1u = u1; r2u = u2; wr = w; ld = l; br = b; busy = bz;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    // reset
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("rst ctl a", 32'(ctl_a), 32'(CTL_HOLD));
    chk("rst ctl b", 32'(ctl_b), 32'(CTL_HOLD));
    chk("rst stall a", 32'(ia.stall_cnt_o), 32'd0);
    chk("rst flush a", 32'(ia.flush_cnt_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post rst ctl a", 32'(ctl_a), 32'(CTL_RUN));

    // load-use: lw x5 then add x6,x5,x1
    drv(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu issue a", 32'(ctl_a), 32'(CTL_RUN));
    step();
    drv(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu stall a", 32'(ctl_a), 32'(CTL_STALL));
    chk("lu stall b", 32'(ctl_b), 32'(CTL_STALL));
    chk("lu stall c", 32'(ctl_c), 32'(CTL_STALL));
    step();
    chk("lu cnt a", 32'(ia.stall_cnt_o), 32'd1);
    chk("lu resume a", 32'(ctl_a), 32'(CTL_RUN));
    chk("lu mem b", 32'(ctl_b), 32'(CTL_STALL));
    chk("lu mem d", 32'(ctl_d), 32'(CTL_STALL));
    step();
    chk("lu wb b", 32'(ctl_b), 32'(CTL_RUN));
    chk("lu wb d", 32'(ctl_d), 32'(CTL_STALL));
    step();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu cnt a2", 32'(ia.stall_cnt_o), 32'd1);
    chk("lu cnt b", 32'(ib.stall_cnt_o), 32'd2);
    chk("lu cnt d", 32'(id.stall_cnt_o), 32'd3);
    step();
    idle(3);

    // ALU RAW: addi x3,x0 then add x4,x3,x3
    drv(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drv(5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("raw ex a", 32'(ctl_a), 32'(CTL_RUN));
    chk("raw ex b", 32'(ctl_b), 32'(CTL_STALL));
    step();
    chk("raw mem a", 32'(ctl_a), 32'(CTL_RUN));
    chk("raw mem b", 32'(ctl_b), 32'(CTL_STALL));
    step();
    chk("raw wb b", 32'(ctl_b), 32'(CTL_RUN));
    chk("raw wb d", 32'(ctl_d), 32'(CTL_STALL));
    step();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("raw cnt a", 32'(ia.stall_cnt_o), 32'd1);
    chk("raw cnt b", 32'(ib.stall_cnt_o), 32'd4);
    chk("raw cnt d", 32'(id.stall_cnt_o), 32'd6);
    step();
    idle(3);

    // x0 writer then x0 reader: never a hazard
    drv(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drv(5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("x0 a", 32'(ctl_a), 32'(CTL_RUN));
    chk("x0 b", 32'(ctl_b), 32'(CTL_RUN));
    chk("x0 d", 32'(ctl_d), 32'(CTL_RUN));
    step();
    idle(3);

    // taken branch coinciding with load-use
    drv(5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drv(5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("br a", 32'(ctl_a), 32'(CTL_FLUSH));
    chk("br b", 32'(ctl_b), 32'(CTL_FLUSH));
    step();
    drv(5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("br bubble a", 32'(ctl_a), 32'(CTL_RUN));
    chk("br fcnt a", 32'(ia.flush_cnt_o), 32'd1);
    chk("br scnt a", 32'(ia.stall_cnt_o), 32'd1);
    chk("br fcnt b", 32'(ib.flush_cnt_o), 32'd1);
    step();
    idle(4);

    // LSU busy for 3 cycles over a pending load-use (branch ignored meanwhile)
    drv(5'd9, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drv(5'd10, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, (i == 1), 1'b1);
      chk("busy hold a", 32'(ctl_a), 32'(CTL_HOLD));
      step();
    end
    chk("busy scnt a", 32'(ia.stall_cnt_o), 32'd1);
    chk("busy fcnt a", 32'(ia.flush_cnt_o), 32'd1);
    drv(5'd10, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy drop a", 32'(ctl_a), 32'(CTL_STALL));
    step();
    chk("busy after a", 32'(ctl_a), 32'(CTL_RUN));
    chk("busy scnt a2", 32'(ia.stall_cnt_o), 32'd2);
    step();
    idle(3);

    // 20 load-use pairs: 4-bit counter saturates
    for (int i = 0; i < 20; i++) begin
      drv(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      drv(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("sat c", 32'(ic.stall_cnt_o), 32'd15);
    chk("sat a", 32'(ia.stall_cnt_o), 32'd22);

    // reset pulse during a stall
    drv(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drv(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre rst c", 32'(ctl_c), 32'(CTL_STALL));
    rst_n = 1'b0;
    #1;
    chk("mid rst c", 32'(ctl_c), 32'(CTL_HOLD));
    step();
    rst_n = 1'b1;
    #1;
    chk("rel ctl c", 32'(ctl_c), 32'(CTL_RUN));
    chk("rel scnt c", 32'(ic.stall_cnt_o), 32'd0);
    chk("rel fcnt c", 32'(ic.flush_cnt_o), 32'd0);
    chk("rel scnt a", 32'(ia.stall_cnt_o), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
